// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - deskewing per-column FIFO bank that emits aligned systolic-array rows
module output_buffer #(
    parameter int COLS       = 4,
    parameter int DWIDTH     = 32,
    parameter int DEPTH      = 16,
    parameter int FRAME_ROWS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COLS-1:0]          i_valid,
    input  logic [COLS*DWIDTH-1:0]   i_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [COLS*DWIDTH-1:0]   o_data,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_rows,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;

    logic [DWIDTH-1:0] mem  [COLS][DEPTH];
    logic [AW-1:0]     wptr [COLS];
    logic [AW-1:0]     rptr [COLS];
    logic [CW-1:0]     occ  [COLS];
    logic [RW-1:0]     row_cnt;
    logic [CW-1:0]     rows_min;
    logic [COLS-1:0]   full;
    logic [COLS-1:0]   wr_en;
    logic [COLS-1:0]   drop;
    logic              pop;

    // A row is complete once the emptiest column holds at least one word.
    always_comb begin
        rows_min = occ[0];
        for (int c = 1; c < COLS; c++) begin
            if (occ[c] < rows_min) rows_min = occ[c];
        end
    end

    assign o_rows  = rows_min;
    assign o_valid = (rows_min != '0);
    assign pop     = o_valid && o_ready;
    assign o_last  = o_valid && (row_cnt == RW'(FRAME_ROWS - 1));

    // A pop frees a slot in the same cycle, so a full column still accepts its write.
    always_comb begin
        full  = '0;
        wr_en = '0;
        drop  = '0;
        for (int c = 0; c < COLS; c++) begin
            full[c]  = (occ[c] == CW'(DEPTH));
            wr_en[c] = !rst && i_valid[c] && (!full[c] || pop);
            drop[c]  = !rst && i_valid[c] && full[c] && !pop;
        end
    end

    always_comb begin
        o_data = '0;
        for (int c = 0; c < COLS; c++) begin
            o_data[c*DWIDTH +: DWIDTH] = mem[c][rptr[c]];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < COLS; c++) begin
            if (wr_en[c]) mem[c][wptr[c]] <= i_data[c*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                occ[c]  <= '0;
            end
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_en[c]) wptr[c] <= wptr[c] + 1'b1;
                if (pop)      rptr[c] <= rptr[c] + 1'b1;
                case ({wr_en[c], pop})
                    2'b10:   occ[c] <= occ[c] + 1'b1;
                    2'b01:   occ[c] <= occ[c] - 1'b1;
                    default: occ[c] <= occ[c];
                endcase
            end
            if (|drop) overflow <= 1'b1;
            if (pop) begin
                if (row_cnt == RW'(FRAME_ROWS - 1)) row_cnt <= '0;
                else                                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - scoreboard bench for output_buffer with directed scenarios
module tb_output_buffer;

    localparam int COLS = 4;
    localparam int DW   = 32;
    localparam int DEP  = 16;
    localparam int FR   = 8;
    localparam int W    = COLS * DW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [COLS-1:0]       i_valid;
    logic [W-1:0]          i_data;
    logic                  o_valid;
    logic                  o_ready;
    logic [W-1:0]          o_data;
    logic                  o_last;
    logic [$clog2(DEP):0]  o_rows;
    logic                  overflow;

    int checks = 0;
    int errors = 0;
    int row_cnt = 0;
    int popped = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] held;
    logic         held_last;

    output_buffer #(.COLS(COLS), .DWIDTH(DW), .DEPTH(DEP), .FRAME_ROWS(FR)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .o_rows(o_rows), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] row_of(input int r, input int cmul);
        logic [W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'(c * cmul + r);
        return v;
    endfunction

    // Compare the head row against the scoreboard whenever the DUT hands one over.
    task automatic check_out();
        logic [W-1:0] exp;
        if (!rst && o_valid && o_ready) begin
            check("sb_nonempty", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("row_data", o_data, exp);
                check("row_last", W'(o_last), W'(row_cnt == FR - 1));
                row_cnt = (row_cnt + 1) % FR;
                popped++;
            end
        end
    endtask

    task automatic tick();
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = '0;
        i_data = '0;
        o_ready = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
        row_cnt = 0;
        popped = 0;
        check("rst_valid", W'(o_valid), W'(0));
        check("rst_last", W'(o_last), W'(0));
        check("rst_rows", W'(o_rows), W'(0));
        check("rst_overflow", W'(overflow), W'(0));
    endtask

    // Column c carries row r on cycle r+c, the array's natural skew.
    task automatic skew_write(input int first, input int n, input int cmul, input bit chk_lat);
        for (int t = 0; t < n + COLS - 1; t++) begin
            if (chk_lat && t <= COLS) check("first_valid", W'(o_valid), W'(t == COLS));
            for (int c = 0; c < COLS; c++) begin
                if (t - c >= 0 && t - c < n) begin
                    i_valid[c] = 1'b1;
                    i_data[c*DW +: DW] = DW'(c * cmul + first + t - c);
                end else begin
                    i_valid[c] = 1'b0;
                    i_data[c*DW +: DW] = '0;
                end
            end
            if (t < n) sb.push_back(row_of(first + t, cmul));
            tick();
        end
        i_valid = '0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        o_ready = 1'b1;
        i_valid = '0;
        while (sb.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_empty", W'(sb.size()), W'(0));
        check("drain_valid", W'(o_valid), W'(0));
        check("drain_rows", W'(o_rows), W'(0));
    endtask

    initial begin
        logic [W-1:0] v;

        // Skewed fill with first-row latency
        do_reset();
        o_ready = 1'b1;
        skew_write(0, 4, 16, 1'b1);
        drain(50);
        check("fill_popped", W'(popped), W'(4));

        // Backpressure: three rows held stable, then drained one per cycle
        do_reset();
        skew_write(0, 3, 65536, 1'b0);
        check("bp_valid", W'(o_valid), W'(1));
        check("bp_rows", W'(o_rows), W'(3));
        held = o_data;
        held_last = o_last;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_data", o_data, held);
            check("bp_hold_last", W'(o_last), W'(held_last));
            check("bp_hold_rows", W'(o_rows), W'(3));
        end
        o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_rows", W'(o_rows), W'(3 - k));
            if (k < 3) tick();
        end
        check("bp_empty", W'(sb.size()), W'(0));

        // Overflow on column 0 only
        do_reset();
        for (int k = 0; k < 17; k++) begin
            i_valid = 4'b0001;
            i_data = '0;
            i_data[DW-1:0] = DW'(256 + k);
            if (k == 16) check("ovf_before", W'(overflow), W'(0));
            tick();
        end
        i_valid = '0;
        check("ovf_set", W'(overflow), W'(1));
        check("ovf_rows", W'(o_rows), W'(0));
        for (int k = 0; k < 16; k++) begin
            i_valid = 4'b1110;
            v = row_of(k, 65536);
            i_data = v;
            v[DW-1:0] = DW'(256 + k);
            sb.push_back(v);
            tick();
        end
        i_valid = '0;
        check("ovf_full_rows", W'(o_rows), W'(16));
        drain(50);
        check("ovf_sticky", W'(overflow), W'(1));

        // All columns full, write and pop in the same cycle
        do_reset();
        for (int k = 0; k < 16; k++) begin
            i_valid = '1;
            i_data = row_of(k, 65536);
            sb.push_back(row_of(k, 65536));
            tick();
        end
        i_valid = '0;
        check("full_rows", W'(o_rows), W'(16));
        o_ready = 1'b1;
        i_valid = '1;
        i_data = row_of(16, 65536);
        sb.push_back(row_of(16, 65536));
        tick();
        i_valid = '0;
        o_ready = 1'b0;
        check("full_no_ovf", W'(overflow), W'(0));
        check("full_rows_kept", W'(o_rows), W'(16));
        check("full_next_head", o_data, row_of(1, 65536));
        drain(50);

        // Long stream across two pointer wraps, frame markers every 8 rows
        do_reset();
        o_ready = 1'b1;
        skew_write(0, 40, 65536, 1'b0);
        drain(50);
        check("stream_popped", W'(popped), W'(40));

        // Mid-frame reset restarts the frame
        do_reset();
        skew_write(0, 7, 65536, 1'b0);
        o_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        o_ready = 1'b0;
        check("mid_rows", W'(o_rows), W'(2));
        do_reset();
        o_ready = 1'b1;
        skew_write(100, 8, 65536, 1'b0);
        drain(50);
        check("mid_popped", W'(popped), W'(8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
